// File: rtl/rd_txn_manager.sv
// Read transaction tracker for the AXI monitor: per-ID in-order lists of outstanding AR
// requests with timeout budgets. Define RD_LAST_CHECK_EN to add per-beat burst-length checking.

module rd_entry_timer #(
    parameter int CntWidth = 10
) (
    input  logic                occupied,
    input  logic                tick,
    input  logic [CntWidth-1:0] counter,
    input  logic [CntWidth-1:0] elapsed,
    output logic [CntWidth-1:0] counter_nxt,
    output logic [CntWidth-1:0] elapsed_nxt,
    output logic                expired
);
    assign counter_nxt = (occupied && tick && counter != '0) ? counter - 1'b1 : counter;
    assign elapsed_nxt = (occupied && tick && elapsed != '1) ? elapsed + 1'b1 : elapsed;
    assign expired     = occupied && (counter == '0);
endmodule

module rd_txn_manager #(
    parameter int MaxRdTxns    = 4,
    parameter int HtCapacity   = 4,
    parameter int IdWidth      = 4,
    parameter int CntWidth     = 10,
    parameter int PrescalerDiv = 1,
    parameter int BudgetBase   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             tick_i,
    input  logic                             ar_valid_i,
    input  logic                             ar_ready_i,
    input  logic [IdWidth-1:0]               ar_id_i,
    input  logic [7:0]                       ar_len_i,
    input  logic                             r_valid_i,
    input  logic                             r_ready_i,
    input  logic [IdWidth-1:0]               r_id_i,
    input  logic                             r_last_i,
    input  logic                             irq_clear_i,
    output logic                             full_o,
    output logic [$clog2(MaxRdTxns+1)-1:0]   outstanding_o,
    output logic [CntWidth-1:0]              latency_o,
    output logic                             latency_valid_o,
    output logic                             reset_req_o,
    output logic                             irq_o,
    output logic                             irq_rd_timeout_o,
    output logic                             irq_unwanted_o,
    output logic                             irq_last_mismatch_o,
    output logic [IdWidth-1:0]               irq_id_o
);
    localparam int LdW     = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    localparam int HtW     = (HtCapacity > 1) ? $clog2(HtCapacity) : 1;
    localparam int OutW    = $clog2(MaxRdTxns + 1);
    localparam int PsShift = $clog2(PrescalerDiv);
    localparam int WideW   = CntWidth + 10;

    typedef struct packed {
        logic [IdWidth-1:0]  id;
`ifdef RD_LAST_CHECK_EN
        logic [7:0]          len;
        logic [7:0]          beat_cnt;
`endif
        logic [CntWidth-1:0] counter;
        logic [CntWidth-1:0] elapsed;
        logic [LdW-1:0]      next;
        logic                free;
    } ld_entry_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [LdW-1:0]     head;
        logic [LdW-1:0]     tail;
        logic               valid;
    } ht_entry_t;

    function automatic ld_entry_t ld_reset();
        ld_entry_t e;
        e      = '0;
        e.free = 1'b1;
        return e;
    endfunction

    ld_entry_t [MaxRdTxns-1:0]  ld_q, ld_d;
    ht_entry_t [HtCapacity-1:0] ht_q, ht_d;

    logic [MaxRdTxns-1:0][CntWidth-1:0] cnt_nxt, ela_nxt;
    logic [MaxRdTxns-1:0]               expired;

    for (genvar g = 0; g < MaxRdTxns; g++) begin : g_tmr
        rd_entry_timer #(.CntWidth(CntWidth)) u_tmr (
            .occupied    (!ld_q[g].free),
            .tick        (tick_i),
            .counter     (ld_q[g].counter),
            .elapsed     (ld_q[g].elapsed),
            .counter_nxt (cnt_nxt[g]),
            .elapsed_nxt (ela_nxt[g]),
            .expired     (expired[g])
        );
    end

    logic            ld_free_found, ht_free_found, ar_hit, r_hit, to_found;
    logic [LdW-1:0]  ld_free_idx, to_idx, head_idx;
    logic [HtW-1:0]  ht_free_idx, ar_ht_idx, r_ht_idx;
    logic [OutW-1:0] occ_cnt;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        ld_free_found = 1'b0; ld_free_idx = '0;
        to_found      = 1'b0; to_idx      = '0;
        occ_cnt       = '0;
        for (int i = MaxRdTxns - 1; i >= 0; i--) begin
            if (ld_q[i].free) begin ld_free_found = 1'b1; ld_free_idx = LdW'(i); end
            if (expired[i])   begin to_found = 1'b1;      to_idx = LdW'(i); end
            occ_cnt = occ_cnt + OutW'(!ld_q[i].free);
        end
        ht_free_found = 1'b0; ht_free_idx = '0;
        ar_hit = 1'b0; ar_ht_idx = '0;
        r_hit  = 1'b0; r_ht_idx  = '0;
        for (int j = HtCapacity - 1; j >= 0; j--) begin
            if (!ht_q[j].valid) begin ht_free_found = 1'b1; ht_free_idx = HtW'(j); end
            if (ht_q[j].valid && ht_q[j].id == ar_id_i) begin ar_hit = 1'b1; ar_ht_idx = HtW'(j); end
            if (ht_q[j].valid && ht_q[j].id == r_id_i)  begin r_hit  = 1'b1; r_ht_idx  = HtW'(j); end
        end
    end

    assign full_o        = !ld_free_found || !ht_free_found;
    assign outstanding_o = occ_cnt;
    assign head_idx      = ht_q[r_ht_idx].head;

    logic ar_fire, r_fire, ar_drop, r_unwanted, r_mismatch, err, retire, enq, same_pop;
    logic [IdWidth-1:0] err_id;

    assign ar_fire    = ar_valid_i && ar_ready_i;
    assign r_fire     = r_valid_i && r_ready_i;
    assign ar_drop    = ar_fire && full_o;
    assign r_unwanted = r_fire && !r_hit;
`ifdef RD_LAST_CHECK_EN
    assign r_mismatch = r_fire && r_hit &&
                        (r_last_i ? (ld_q[head_idx].beat_cnt != ld_q[head_idx].len)
                                  : (ld_q[head_idx].beat_cnt == ld_q[head_idx].len));
`else
    assign r_mismatch = 1'b0;
`endif
    assign err      = to_found || r_unwanted || r_mismatch || ar_drop;
    assign retire   = r_fire && r_hit && r_last_i && !r_mismatch;
    assign enq      = ar_fire && !full_o;
    assign same_pop = retire && ar_hit && (r_ht_idx == ar_ht_idx) &&
                      (ht_q[r_ht_idx].head == ht_q[r_ht_idx].tail);
    assign err_id   = to_found ? ld_q[to_idx].id :
                      (r_unwanted || r_mismatch) ? r_id_i : ar_id_i;
    assign reset_req_o = err;

    logic [WideW-1:0]    budget_wide;
    logic [CntWidth-1:0] budget;
    assign budget_wide = WideW'(BudgetBase) + WideW'(ar_len_i >> PsShift) + WideW'(2);
    assign budget      = (budget_wide > WideW'({CntWidth{1'b1}})) ? '1 : budget_wide[CntWidth-1:0];

    always_comb begin
        ld_d = ld_q;
        ht_d = ht_q;
        for (int i = 0; i < MaxRdTxns; i++) begin
            ld_d[i].counter = cnt_nxt[i];
            ld_d[i].elapsed = ela_nxt[i];
        end
`ifdef RD_LAST_CHECK_EN
        if (r_fire && r_hit)
            ld_d[head_idx].beat_cnt = ld_q[head_idx].beat_cnt + 8'd1;
`endif
        // Pop before push so a single-entry list hit by both restarts as a fresh list.
        if (retire) begin
            ld_d[head_idx] = ld_reset();
            if (ht_q[r_ht_idx].head == ht_q[r_ht_idx].tail)
                ht_d[r_ht_idx].valid = 1'b0;
            else
                ht_d[r_ht_idx].head = ld_q[head_idx].next;
        end
        if (enq) begin
            ld_d[ld_free_idx]         = '0;
            ld_d[ld_free_idx].id      = ar_id_i;
`ifdef RD_LAST_CHECK_EN
            ld_d[ld_free_idx].len     = ar_len_i;
`endif
            ld_d[ld_free_idx].counter = budget;
            if (ar_hit && !same_pop) begin
                ld_d[ht_q[ar_ht_idx].tail].next = ld_free_idx;
                ht_d[ar_ht_idx].tail            = ld_free_idx;
            end else if (ar_hit) begin
                ht_d[ar_ht_idx] = '{id: ar_id_i, head: ld_free_idx, tail: ld_free_idx, valid: 1'b1};
            end else begin
                ht_d[ht_free_idx] = '{id: ar_id_i, head: ld_free_idx, tail: ld_free_idx, valid: 1'b1};
            end
        end
        if (err) begin
            for (int i = 0; i < MaxRdTxns; i++) ld_d[i] = ld_reset();
            for (int j = 0; j < HtCapacity; j++) ht_d[j] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxRdTxns; i++) ld_q[i] <= ld_reset();
            ht_q            <= '0;
            latency_o       <= '0;
            latency_valid_o <= 1'b0;
        end else begin
            ld_q            <= ld_d;
            ht_q            <= ht_d;
            latency_valid_o <= retire && !err;
            if (retire && !err) latency_o <= ld_q[head_idx].elapsed;
        end
    end

    logic irq_mismatch_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_rd_timeout_o <= 1'b0;
            irq_unwanted_o   <= 1'b0;
            irq_mismatch_q   <= 1'b0;
            irq_id_o         <= '0;
        end else begin
            if (irq_clear_i) begin
                irq_rd_timeout_o <= 1'b0;
                irq_unwanted_o   <= 1'b0;
                irq_mismatch_q   <= 1'b0;
                irq_id_o         <= '0;
            end
            if (to_found)                 irq_rd_timeout_o <= 1'b1;
            if (r_unwanted || ar_drop)    irq_unwanted_o   <= 1'b1;
            if (r_mismatch)               irq_mismatch_q   <= 1'b1;
            // Only the first error after a clear records its ID; a coinciding clear yields to it.
            if (err && (!irq_o || irq_clear_i)) irq_id_o <= err_id;
        end
    end

`ifdef RD_LAST_CHECK_EN
    assign irq_last_mismatch_o = irq_mismatch_q;
`else
    assign irq_last_mismatch_o = 1'b0;
    logic unused_mismatch;
    assign unused_mismatch = irq_mismatch_q;
`endif
    assign irq_o = irq_rd_timeout_o || irq_unwanted_o || irq_last_mismatch_o;

endmodule

// File: tb/tb_rd_txn_manager.sv
// Directed bench for rd_txn_manager; expectations are hand-computed from the default parameters.

module tb_rd_txn_manager;
    logic       clk_i = 1'b0, rst_ni = 1'b0, tick_i = 1'b0;
    logic       ar_valid_i = 1'b0, ar_ready_i = 1'b0;
    logic [3:0] ar_id_i = '0;
    logic [7:0] ar_len_i = '0;
    logic       r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
    logic [3:0] r_id_i = '0;
    logic       irq_clear_i = 1'b0;
    logic       full_o, latency_valid_o, reset_req_o, irq_o;
    logic       irq_rd_timeout_o, irq_unwanted_o, irq_last_mismatch_o;
    logic [2:0] outstanding_o;
    logic [9:0] latency_o;
    logic [3:0] irq_id_o;

    int checks = 0;
    int errors = 0;
    int n;

    rd_txn_manager dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_id_i(r_id_i), .r_last_i(r_last_i),
        .irq_clear_i(irq_clear_i), .full_o(full_o), .outstanding_o(outstanding_o),
        .latency_o(latency_o), .latency_valid_o(latency_valid_o), .reset_req_o(reset_req_o),
        .irq_o(irq_o), .irq_rd_timeout_o(irq_rd_timeout_o), .irq_unwanted_o(irq_unwanted_o),
        .irq_last_mismatch_o(irq_last_mismatch_o), .irq_id_o(irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ar(input logic [3:0] id, input logic [7:0] len);
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = id; ar_len_i = len;
        cyc();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
    endtask

    task automatic rbeat(input logic [3:0] id, input logic last);
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = id; r_last_i = last;
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
    endtask

    task automatic ticks(input int k);
        tick_i = 1'b1;
        repeat (k) cyc();
        tick_i = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clear_i = 1'b1;
        cyc();
        irq_clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_full", full_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_reset_req", reset_req_o, 0);
        chk("rst_lat_valid", latency_valid_o, 0);
        chk("rst_irq_id", irq_id_o, 0);
        rst_ni = 1'b1;
        cyc();

        // single burst id=3 len=3, one tick before each beat
        ar(4'd3, 8'd3);
        chk("t1_outstanding", outstanding_o, 1);
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            rbeat(4'd3, i == 3);
        end
        chk("t1_lat_valid", latency_valid_o, 1);
        chk("t1_latency", latency_o, 4);
        chk("t1_outstanding0", outstanding_o, 0);
        chk("t1_irq", irq_o, 0);
        cyc();
        chk("t1_lat_pulse", latency_valid_o, 0);

        // two in-order reads on id=1
        ar(4'd1, 8'd0);
        ticks(2);
        ar(4'd1, 8'd0);
        ticks(1);
        rbeat(4'd1, 1'b1);
        chk("t2_lat1", latency_o, 3);
        chk("t2_lat1_valid", latency_valid_o, 1);
        chk("t2_outstanding1", outstanding_o, 1);
        ticks(1);
        rbeat(4'd1, 1'b1);
        chk("t2_lat2", latency_o, 2);
        chk("t2_outstanding0", outstanding_o, 0);
        chk("t2_irq", irq_o, 0);

        // same-cycle AR and last R on a single-entry list
        ar(4'd6, 8'd0);
        ticks(1);
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd6; ar_len_i = 8'd0;
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd6; r_last_i = 1'b1;
        cyc();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0; r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("t3_lat_pop", latency_o, 1);
        chk("t3_outstanding", outstanding_o, 1);
        ticks(2);
        rbeat(4'd6, 1'b1);
        chk("t3_lat_new", latency_o, 2);
        chk("t3_outstanding0", outstanding_o, 0);
        chk("t3_irq", irq_o, 0);

        // timeout: budget 10 with tick held
        ar(4'd2, 8'd0);
        tick_i = 1'b1;
        n = 0;
        while (!reset_req_o && n < 30) begin
            cyc();
            n++;
        end
        tick_i = 1'b0;
        chk("t4_timeout_ticks", n, 10);
        chk("t4_reset_req", reset_req_o, 1);
        cyc();
        chk("t4_irq_timeout", irq_rd_timeout_o, 1);
        chk("t4_irq_id", irq_id_o, 2);
        chk("t4_outstanding", outstanding_o, 0);
        chk("t4_reset_pulse", reset_req_o, 0);
        clear_irq();
        chk("t4_cleared", irq_o, 0);

        // unwanted R, first-error ID, clear coinciding with error
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd5; r_last_i = 1'b1;
        #1;
        chk("t5_reset_req", reset_req_o, 1);
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("t5_unwanted", irq_unwanted_o, 1);
        chk("t5_irq_id", irq_id_o, 5);
        rbeat(4'd7, 1'b1);
        chk("t5_first_id", irq_id_o, 5);
        irq_clear_i = 1'b1;
        rbeat(4'd9, 1'b0);
        irq_clear_i = 1'b0;
        chk("t5_err_wins", irq_unwanted_o, 1);
        chk("t5_err_wins_id", irq_id_o, 9);
        clear_irq();
        chk("t5_cleared", irq_unwanted_o, 0);

        // fill, then overflow
        for (int i = 0; i < 4; i++) ar(4'(i), 8'd0);
        chk("t6_full", full_o, 1);
        chk("t6_outstanding", outstanding_o, 4);
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_id_i = 4'd12; ar_len_i = 8'd0;
        #1;
        chk("t6_reset_req", reset_req_o, 1);
        cyc();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        chk("t6_unwanted", irq_unwanted_o, 1);
        chk("t6_irq_id", irq_id_o, 12);
        chk("t6_outstanding0", outstanding_o, 0);
        chk("t6_full0", full_o, 0);
        clear_irq();

        // early r_last on the 2nd beat of a len=3 burst
        ar(4'd4, 8'd3);
        ticks(2);
        rbeat(4'd4, 1'b0);
`ifdef RD_LAST_CHECK_EN
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_id_i = 4'd4; r_last_i = 1'b1;
        #1;
        chk("t7_reset_req", reset_req_o, 1);
        cyc();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("t7_mismatch", irq_last_mismatch_o, 1);
        chk("t7_irq_id", irq_id_o, 4);
        chk("t7_no_lat", latency_valid_o, 0);
        chk("t7_outstanding", outstanding_o, 0);
        clear_irq();
`else
        rbeat(4'd4, 1'b1);
        chk("t7_lat_valid", latency_valid_o, 1);
        chk("t7_latency", latency_o, 2);
        chk("t7_mismatch", irq_last_mismatch_o, 0);
        chk("t7_outstanding", outstanding_o, 0);
`endif

        // async reset mid-burst
        ar(4'd8, 8'd3);
        rbeat(4'd8, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t8_outstanding", outstanding_o, 0);
        chk("t8_reset_req", reset_req_o, 0);
        chk("t8_irq", irq_o, 0);
        #3;
        rst_ni = 1'b1;
        cyc();
        chk("t8_lat_valid", latency_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
